processor: RTL and testbench

- Instruction-decode control unit for the ARM-LP (LEGv8-style) core.
- Takes a 32-bit instruction word and produces the registered control signals consumed by the register file, ALU, data memory and branch logic: write/read enables, ALU operand source, ALU operation code, branch type and operation class.
- Pure decoder, one pipeline register; no datapath.

---
 rtl/processor.sv | 162 ++++++++++++++++
 tb/tb_processor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/processor.sv
// Instruction-decode control unit for the ARM-LP core.
// Decodes cls/sub fields into control flags held in one output register stage.
module processor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic        regWriteFlag,
  output logic [2:0]  opType,
  output logic        memWriteFlag,
  output logic        memReadFlag,
  output logic [3:0]  aluControlCode,
  output logic        branchFlag,
  output logic        unconditionalBranchFlag,
  output logic        aluSRC
);

  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd10;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_NAND = 4'd12;
  localparam logic [3:0] ALU_MOV  = 4'd13;
  localparam logic [3:0] ALU_CBZ  = 4'd7;

  localparam logic [2:0] OP_R       = 3'd0;
  localparam logic [2:0] OP_I       = 3'd1;
  localparam logic [2:0] OP_LOAD    = 3'd2;
  localparam logic [2:0] OP_STORE   = 3'd3;
  localparam logic [2:0] OP_CBZ     = 3'd4;
  localparam logic [2:0] OP_B       = 3'd5;
  localparam logic [2:0] OP_MOV     = 3'd6;
  localparam logic [2:0] OP_INVALID = 3'd7;

  logic [3:0] w_cls;
  logic [3:0] w_sub;
  logic       w_unused;

  logic       w_regWrite;
  logic [2:0] w_opType;
  logic       w_memWrite;
  logic       w_memRead;
  logic [3:0] w_alu;
  logic       w_branch;
  logic       w_uBranch;
  logic       w_aluSrc;

  logic       r_regWrite;
  logic [2:0] r_opType;
  logic       r_memWrite;
  logic       r_memRead;
  logic [3:0] r_alu;
  logic       r_branch;
  logic       r_uBranch;
  logic       r_aluSrc;

  assign w_cls    = instruction[29:26];
  assign w_sub    = instruction[25:22];
  assign w_unused = ^{instruction[31:30], instruction[21:0]};

  // Defaults equal the reset state, so any unlisted encoding decodes as invalid.
  always_comb begin
    w_regWrite = 1'b0;
    w_opType   = OP_INVALID;
    w_memWrite = 1'b0;
    w_memRead  = 1'b0;
    w_alu      = 4'd0;
    w_branch   = 1'b0;
    w_uBranch  = 1'b0;
    w_aluSrc   = 1'b0;
    case (w_cls)
      4'b0010: begin
        if (!w_sub[3]) begin
          w_regWrite = 1'b1;
          w_opType   = OP_R;
          case (w_sub[2:0])
            3'd0:    w_alu = ALU_ADD;
            3'd1:    w_alu = ALU_SUB;
            3'd2:    w_alu = ALU_AND;
            3'd3:    w_alu = ALU_OR;
            3'd4:    w_alu = ALU_XOR;
            3'd5:    w_alu = ALU_NOR;
            3'd6:    w_alu = ALU_NAND;
            default: w_alu = ALU_MOV;
          endcase
        end
      end
      4'b0110: begin
        w_opType   = OP_STORE;
        w_memWrite = 1'b1;
        w_aluSrc   = 1'b1;
        w_alu      = ALU_ADD;
      end
      4'b0100: begin
        if (w_sub <= 4'd6) begin
          w_regWrite = 1'b1;
          w_aluSrc   = 1'b1;
          w_opType   = OP_I;
          case (w_sub)
            4'd0: w_alu = ALU_ADD;
            4'd1: begin
              w_opType  = OP_LOAD;
              w_memRead = 1'b1;
              w_alu     = ALU_ADD;
            end
            4'd2: begin
              w_opType = OP_MOV;
              w_alu    = ALU_MOV;
            end
            4'd3:    w_alu = ALU_SUB;
            4'd4:    w_alu = ALU_AND;
            4'd5:    w_alu = ALU_OR;
            default: w_alu = ALU_XOR;
          endcase
        end
      end
      4'b1001: begin
        w_opType = OP_CBZ;
        w_branch = 1'b1;
        w_alu    = ALU_CBZ;
      end
      4'b0001: begin
        w_opType  = OP_B;
        w_uBranch = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_regWrite <= 1'b0;
      r_opType   <= OP_INVALID;
      r_memWrite <= 1'b0;
      r_memRead  <= 1'b0;
      r_alu      <= 4'd0;
      r_branch   <= 1'b0;
      r_uBranch  <= 1'b0;
      r_aluSrc   <= 1'b0;
    end else begin
      r_regWrite <= w_regWrite;
      r_opType   <= w_opType;
      r_memWrite <= w_memWrite;
      r_memRead  <= w_memRead;
      r_alu      <= w_alu;
      r_branch   <= w_branch;
      r_uBranch  <= w_uBranch;
      r_aluSrc   <= w_aluSrc;
    end
  end

  assign regWriteFlag            = r_regWrite;
  assign opType                  = r_opType;
  assign memWriteFlag            = r_memWrite;
  assign memReadFlag             = r_memRead;
  assign aluControlCode          = r_alu;
  assign branchFlag              = r_branch;
  assign unconditionalBranchFlag = r_uBranch;
  assign aluSRC                  = r_aluSrc;

endmodule

// File: tb/tb_processor.sv
// Scoreboard bench for processor: the driver queues hand-computed control words,
// the monitor pops one per clock edge and compares against the registered outputs.
module tb_processor;

  typedef struct packed {
    logic       rw;
    logic [2:0] op;
    logic       mw;
    logic       mr;
    logic [3:0] alu;
    logic       br;
    logic       ub;
    logic       src;
  } ctrl_t;

  typedef struct {
    ctrl_t exp;
    string name;
  } sbEntry_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        regWriteFlag;
  logic [2:0]  opType;
  logic        memWriteFlag;
  logic        memReadFlag;
  logic [3:0]  aluControlCode;
  logic        branchFlag;
  logic        unconditionalBranchFlag;
  logic        aluSRC;

  sbEntry_t scoreboard[$];
  int       checkCount = 0;
  int       failCount  = 0;

  ctrl_t expRst, expLdur, expCbz, expRadd, expStur, expAddi, expB, expMov;

  processor dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .instruction             (instruction),
    .regWriteFlag            (regWriteFlag),
    .opType                  (opType),
    .memWriteFlag            (memWriteFlag),
    .memReadFlag             (memReadFlag),
    .aluControlCode          (aluControlCode),
    .branchFlag              (branchFlag),
    .unconditionalBranchFlag (unconditionalBranchFlag),
    .aluSRC                  (aluSRC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctrl_t mk(input logic rw, input logic [2:0] op, input logic mw,
                               input logic mr, input logic [3:0] alu, input logic br,
                               input logic ub, input logic src);
    ctrl_t c;
    c.rw = rw; c.op = op; c.mw = mw; c.mr = mr;
    c.alu = alu; c.br = br; c.ub = ub; c.src = src;
    return c;
  endfunction

  function automatic ctrl_t dutCtrl();
    return mk(regWriteFlag, opType, memWriteFlag, memReadFlag, aluControlCode,
              branchFlag, unconditionalBranchFlag, aluSRC);
  endfunction

  task automatic applyStimulus(input logic [31:0] instr, input logic rstn,
                               input ctrl_t exp, input string name);
    sbEntry_t e;
    @(negedge clk);
    instruction = instr;
    rst_n       = rstn;
    e.exp  = exp;
    e.name = name;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input ctrl_t exp, input string name);
    ctrl_t got;
    got = dutCtrl();
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got rw=%0d op=%0d mw=%0d mr=%0d alu=%0d br=%0d ub=%0d src=%0d, expected rw=%0d op=%0d mw=%0d mr=%0d alu=%0d br=%0d ub=%0d src=%0d",
               name, got.rw, got.op, got.mw, got.mr, got.alu, got.br, got.ub, got.src,
               exp.rw, exp.op, exp.mw, exp.mr, exp.alu, exp.br, exp.ub, exp.src);
    end
  endtask

  // Monitor: one registered result per rising edge once the driver has queued one.
  initial begin
    sbEntry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput(e.exp, e.name);
      end
    end
  end

  // Changes the input mid-cycle; outputs must hold until the next rising edge.
  task automatic latencyCheck(input ctrl_t held);
    @(posedge clk);
    #3;
    instruction = 32'h3C000000;
    #1;
    checkOutput(held, "latency_hold");
  endtask

  initial begin
    logic [3:0] rAlu[8];
    rAlu = '{4'd2, 4'd10, 4'd6, 4'd4, 4'd9, 4'd5, 4'd12, 4'd13};

    expRst  = mk(0, 3'd7, 0, 0, 4'd0,  0, 0, 0);
    expLdur = mk(1, 3'd2, 0, 1, 4'd2,  0, 0, 1);
    expCbz  = mk(0, 3'd4, 0, 0, 4'd7,  1, 0, 0);
    expRadd = mk(1, 3'd0, 0, 0, 4'd2,  0, 0, 0);
    expStur = mk(0, 3'd3, 1, 0, 4'd2,  0, 0, 1);
    expAddi = mk(1, 3'd1, 0, 0, 4'd2,  0, 0, 1);
    expB    = mk(0, 3'd5, 0, 0, 4'd0,  0, 1, 0);
    expMov  = mk(1, 3'd6, 0, 0, 4'd13, 0, 0, 1);

    rst_n       = 1'b0;
    instruction = 32'h0;

    applyStimulus(32'h08000000, 1'b0, expRst, "reset_edge0");
    applyStimulus(32'h10400000, 1'b0, expRst, "reset_edge1");

    applyStimulus(32'h10400000, 1'b1, expLdur, "ldur");
    applyStimulus(32'h24000000, 1'b1, expCbz,  "cbz");
    applyStimulus(32'h08000000, 1'b1, expRadd, "r_add");
    applyStimulus(32'h18000000, 1'b1, expStur, "store");
    applyStimulus(32'h10000000, 1'b1, expAddi, "addi");
    applyStimulus(32'h04000000, 1'b1, expB,    "b");
    applyStimulus(32'h10800000, 1'b1, expMov,  "mov");

    for (int k = 0; k < 8; k++) begin
      applyStimulus(32'h08000000 + (32'(k) << 22), 1'b1,
                    mk(1, 3'd0, 0, 0, rAlu[k], 0, 0, 0), $sformatf("r_funct%0d", k));
    end
    applyStimulus(32'h0A000000, 1'b1, expRst, "r_funct8_invalid");

    applyStimulus(32'h00000000, 1'b1, expRst,  "cls0_invalid");
    applyStimulus(32'h3C000000, 1'b1, expRst,  "cls15_invalid");
    applyStimulus(32'hC8000000, 1'b1, expRadd, "top_bits_ignored");
    applyStimulus(32'h103FFFFF, 1'b1, expAddi, "low_bits_ignored");
    applyStimulus(32'h11C00000, 1'b1, expRst,  "imm_sub7_invalid");
    applyStimulus(32'h11800000, 1'b1, mk(1, 3'd1, 0, 0, 4'd9, 0, 0, 1), "eori");

    applyStimulus(32'h10400000, 1'b1, expLdur, "ldur_before_hold");
    latencyCheck(expLdur);

    applyStimulus(32'h10400000, 1'b1, expLdur, "ldur_before_reset");
    applyStimulus(32'h10400000, 1'b0, expRst,  "midstream_reset");
    applyStimulus(32'h10800000, 1'b1, expMov,  "mov_after_reset");

    for (int i = 0; i < 10 && scoreboard.size() > 0; i++) @(negedge clk);
    if (scoreboard.size() > 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
